// File: rtl/ddr_src_quiesce.sv
// Quiesces the DDR AXI4 path before the source mux changes master.
// AW/AR are gated while draining. W/B/R always pass through untouched.
module ddr_src_quiesce #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ID_WIDTH        = 9,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned DRAIN_TIMEOUT   = 16'hFFFF,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // source select and status
  input  logic [1:0]              sel_req,
  output logic [1:0]              sel_cur,
  output logic                    atg_enable,
  output logic                    scrb_enable,
  output logic                    switch_busy,
  output logic                    drain_err,
  input  logic                    err_clr,
  output logic [CW-1:0]           wr_outstanding,
  output logic [CW-1:0]           rd_outstanding,
  // AW upstream / downstream
  input  logic [ID_WIDTH-1:0]     us_awid,
  input  logic [63:0]             us_awaddr,
  input  logic [7:0]              us_awlen,
  input  logic [2:0]              us_awsize,
  input  logic [10:0]             us_awuser,
  input  logic                    us_awvalid,
  output logic                    us_awready,
  output logic [ID_WIDTH-1:0]     ds_awid,
  output logic [63:0]             ds_awaddr,
  output logic [7:0]              ds_awlen,
  output logic [2:0]              ds_awsize,
  output logic [10:0]             ds_awuser,
  output logic                    ds_awvalid,
  input  logic                    ds_awready,
  // W
  input  logic [ID_WIDTH-1:0]     us_wid,
  input  logic [DATA_WIDTH-1:0]   us_wdata,
  input  logic [DATA_WIDTH/8-1:0] us_wstrb,
  input  logic                    us_wlast,
  input  logic                    us_wvalid,
  output logic                    us_wready,
  output logic [ID_WIDTH-1:0]     ds_wid,
  output logic [DATA_WIDTH-1:0]   ds_wdata,
  output logic [DATA_WIDTH/8-1:0] ds_wstrb,
  output logic                    ds_wlast,
  output logic                    ds_wvalid,
  input  logic                    ds_wready,
  // B
  input  logic [ID_WIDTH-1:0]     ds_bid,
  input  logic [1:0]              ds_bresp,
  input  logic                    ds_bvalid,
  output logic                    ds_bready,
  output logic [ID_WIDTH-1:0]     us_bid,
  output logic [1:0]              us_bresp,
  output logic                    us_bvalid,
  input  logic                    us_bready,
  // AR
  input  logic [ID_WIDTH-1:0]     us_arid,
  input  logic [63:0]             us_araddr,
  input  logic [7:0]              us_arlen,
  input  logic [2:0]              us_arsize,
  input  logic [10:0]             us_aruser,
  input  logic                    us_arvalid,
  output logic                    us_arready,
  output logic [ID_WIDTH-1:0]     ds_arid,
  output logic [63:0]             ds_araddr,
  output logic [7:0]              ds_arlen,
  output logic [2:0]              ds_arsize,
  output logic [10:0]             ds_aruser,
  output logic                    ds_arvalid,
  input  logic                    ds_arready,
  // R
  input  logic [ID_WIDTH-1:0]     ds_rid,
  input  logic [DATA_WIDTH-1:0]   ds_rdata,
  input  logic [1:0]              ds_rresp,
  input  logic                    ds_rlast,
  input  logic                    ds_rvalid,
  output logic                    ds_rready,
  output logic [ID_WIDTH-1:0]     us_rid,
  output logic [DATA_WIDTH-1:0]   us_rdata,
  output logic [1:0]              us_rresp,
  output logic                    us_rlast,
  output logic                    us_rvalid,
  input  logic                    us_rready
);

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  localparam logic [CW-1:0] MaxOut     = CW'(MAX_OUTSTANDING);
  localparam logic [15:0]   TimeoutVal = 16'(DRAIN_TIMEOUT);

  state_e        state_q, state_d;
  logic [1:0]    sel_cur_q, sel_cur_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [15:0]   drain_cnt_q, drain_cnt_d;
  logic          drain_err_q, drain_err_d;
  logic [CW-1:0] wr_q, rd_q, wbeat_q;
  logic          aw_stuck_q, ar_stuck_q;

  logic [1:0] sel_norm;
  logic       aw_open, ar_open;
  logic       aw_hs, ar_hs, wlast_hs, b_hs, rlast_hs;
  logic       drained;

  // Saturating up/down counter step; simultaneous inc and dec cancel.
  function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] cur,
                                            input logic inc, input logic dec);
    if (inc && !dec) begin
      return cur + CW'(1);
    end else if (dec && !inc && (cur != '0)) begin
      return cur - CW'(1);
    end
    return cur;
  endfunction

  // Gates and pass-through. A stuck valid keeps its gate open so AXI valid is never withdrawn.
  always_comb begin
    sel_norm = (sel_req == 2'd3) ? 2'd0 : sel_req;
    aw_open  = ((state_q == StRun) && (wr_q < MaxOut)) || aw_stuck_q;
    ar_open  = ((state_q == StRun) && (rd_q < MaxOut)) || ar_stuck_q;

    ds_awid    = us_awid;
    ds_awaddr  = us_awaddr;
    ds_awlen   = us_awlen;
    ds_awsize  = us_awsize;
    ds_awuser  = us_awuser;
    ds_awvalid = us_awvalid & aw_open;
    us_awready = ds_awready & aw_open;

    ds_arid    = us_arid;
    ds_araddr  = us_araddr;
    ds_arlen   = us_arlen;
    ds_arsize  = us_arsize;
    ds_aruser  = us_aruser;
    ds_arvalid = us_arvalid & ar_open;
    us_arready = ds_arready & ar_open;

    ds_wid    = us_wid;
    ds_wdata  = us_wdata;
    ds_wstrb  = us_wstrb;
    ds_wlast  = us_wlast;
    ds_wvalid = us_wvalid;
    us_wready = ds_wready;

    us_bid    = ds_bid;
    us_bresp  = ds_bresp;
    us_bvalid = ds_bvalid;
    ds_bready = us_bready;

    us_rid    = ds_rid;
    us_rdata  = ds_rdata;
    us_rresp  = ds_rresp;
    us_rlast  = ds_rlast;
    us_rvalid = ds_rvalid;
    ds_rready = us_rready;

    aw_hs    = ds_awvalid & ds_awready;
    ar_hs    = ds_arvalid & ds_arready;
    wlast_hs = us_wvalid & ds_wready & us_wlast;
    b_hs     = ds_bvalid & us_bready;
    rlast_hs = ds_rvalid & us_rready & ds_rlast;

    drained = (wr_q == '0) && (rd_q == '0) && (wbeat_q == '0) && !aw_stuck_q && !ar_stuck_q;
  end

  // Next-state logic for the quiesce FSM, drain timer and sticky error.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    sel_cur_d   = sel_cur_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StRun: begin
        if (sel_norm != sel_cur_q) begin
          state_d     = StDrain;
          tgt_d       = sel_norm;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (drain_cnt_q != 16'hFFFF) drain_cnt_d = drain_cnt_q + 16'd1;
        if (drained) state_d = StSwitch;
      end
      StSwitch: begin
        sel_cur_d = tgt_q;
        state_d   = StRun;
      end
      default: state_d = StRun;
    endcase

    drain_err_d = drain_err_q;
    if ((state_q == StDrain) && (drain_cnt_q == TimeoutVal)) begin
      drain_err_d = 1'b1;
    end else if (err_clr) begin
      drain_err_d = 1'b0;
    end
  end

  // State, counters and stuck flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      sel_cur_q   <= 2'd0;
      tgt_q       <= 2'd0;
      drain_cnt_q <= '0;
      drain_err_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      wbeat_q     <= '0;
      aw_stuck_q  <= 1'b0;
      ar_stuck_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_cur_q   <= sel_cur_d;
      tgt_q       <= tgt_d;
      drain_cnt_q <= drain_cnt_d;
      drain_err_q <= drain_err_d;
      wr_q        <= cnt_upd(wr_q, aw_hs, b_hs);
      rd_q        <= cnt_upd(rd_q, ar_hs, rlast_hs);
      wbeat_q     <= cnt_upd(wbeat_q, aw_hs, wlast_hs);
      aw_stuck_q  <= ds_awvalid & ~ds_awready;
      ar_stuck_q  <= ds_arvalid & ~ds_arready;
    end
  end

  assign sel_cur        = sel_cur_q;
  assign atg_enable     = (sel_cur_q == 2'd1);
  assign scrb_enable    = (sel_cur_q == 2'd2);
  assign switch_busy    = (state_q != StRun);
  assign drain_err      = drain_err_q;
  assign wr_outstanding = wr_q;
  assign rd_outstanding = rd_q;

  // A completion with nothing outstanding means the downstream broke protocol.
  a_b_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(b_hs && !aw_hs && (wr_q == '0))) else $error("B response with no write outstanding");
  a_r_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(rlast_hs && !ar_hs && (rd_q == '0))) else $error("R last with no read outstanding");
  a_w_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(wlast_hs && !aw_hs && (wbeat_q == '0))) else $error("W last with no burst pending");

endmodule

// File: tb/tb_ddr_src_quiesce.sv
// Directed bench for ddr_src_quiesce: gating table plus multi-cycle switch sequences.
module tb_ddr_src_quiesce;

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 9;
  localparam int unsigned CW = 7;

  logic clk, rst_n;
  logic [1:0] sel_req, sel_cur;
  logic atg_enable, scrb_enable, switch_busy, drain_err, err_clr;
  logic [CW-1:0] wr_outstanding, rd_outstanding;

  logic [IW-1:0] us_awid, ds_awid, us_arid, ds_arid;
  logic [63:0] us_awaddr, ds_awaddr, us_araddr, ds_araddr;
  logic [7:0] us_awlen, ds_awlen, us_arlen, ds_arlen;
  logic [2:0] us_awsize, ds_awsize, us_arsize, ds_arsize;
  logic [10:0] us_awuser, ds_awuser, us_aruser, ds_aruser;
  logic us_awvalid, us_awready, ds_awvalid, ds_awready;
  logic us_arvalid, us_arready, ds_arvalid, ds_arready;

  logic [IW-1:0] us_wid, ds_wid;
  logic [DW-1:0] us_wdata, ds_wdata;
  logic [DW/8-1:0] us_wstrb, ds_wstrb;
  logic us_wlast, ds_wlast, us_wvalid, us_wready, ds_wvalid, ds_wready;

  logic [IW-1:0] ds_bid, us_bid;
  logic [1:0] ds_bresp, us_bresp;
  logic ds_bvalid, ds_bready, us_bvalid, us_bready;

  logic [IW-1:0] ds_rid, us_rid;
  logic [DW-1:0] ds_rdata, us_rdata;
  logic [1:0] ds_rresp, us_rresp;
  logic ds_rlast, us_rlast, ds_rvalid, ds_rready, us_rvalid, us_rready;

  int n_vec = 0;
  int n_err = 0;

  ddr_src_quiesce #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(64), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_req(sel_req), .sel_cur(sel_cur), .atg_enable(atg_enable), .scrb_enable(scrb_enable),
    .switch_busy(switch_busy), .drain_err(drain_err), .err_clr(err_clr),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .us_awid(us_awid), .us_awaddr(us_awaddr), .us_awlen(us_awlen), .us_awsize(us_awsize),
    .us_awuser(us_awuser), .us_awvalid(us_awvalid), .us_awready(us_awready),
    .ds_awid(ds_awid), .ds_awaddr(ds_awaddr), .ds_awlen(ds_awlen), .ds_awsize(ds_awsize),
    .ds_awuser(ds_awuser), .ds_awvalid(ds_awvalid), .ds_awready(ds_awready),
    .us_wid(us_wid), .us_wdata(us_wdata), .us_wstrb(us_wstrb), .us_wlast(us_wlast),
    .us_wvalid(us_wvalid), .us_wready(us_wready),
    .ds_wid(ds_wid), .ds_wdata(ds_wdata), .ds_wstrb(ds_wstrb), .ds_wlast(ds_wlast),
    .ds_wvalid(ds_wvalid), .ds_wready(ds_wready),
    .ds_bid(ds_bid), .ds_bresp(ds_bresp), .ds_bvalid(ds_bvalid), .ds_bready(ds_bready),
    .us_bid(us_bid), .us_bresp(us_bresp), .us_bvalid(us_bvalid), .us_bready(us_bready),
    .us_arid(us_arid), .us_araddr(us_araddr), .us_arlen(us_arlen), .us_arsize(us_arsize),
    .us_aruser(us_aruser), .us_arvalid(us_arvalid), .us_arready(us_arready),
    .ds_arid(ds_arid), .ds_araddr(ds_araddr), .ds_arlen(ds_arlen), .ds_arsize(ds_arsize),
    .ds_aruser(ds_aruser), .ds_arvalid(ds_arvalid), .ds_arready(ds_arready),
    .ds_rid(ds_rid), .ds_rdata(ds_rdata), .ds_rresp(ds_rresp), .ds_rlast(ds_rlast),
    .ds_rvalid(ds_rvalid), .ds_rready(ds_rready),
    .us_rid(us_rid), .us_rdata(us_rdata), .us_rresp(us_rresp), .us_rlast(us_rlast),
    .us_rvalid(us_rvalid), .us_rready(us_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] vin;  // awv awrdy arv arrdy wv wrdy bv brdy rv rrdy (input side)
    logic [9:0] vexp; // matching outputs on the opposite side
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    us_awvalid = 0; ds_awready = 0; us_arvalid = 0; ds_arready = 0;
    us_wvalid = 0; us_wlast = 0; ds_wready = 0;
    ds_bvalid = 0; us_bready = 0; ds_rvalid = 0; ds_rlast = 0; us_rready = 0;
  endtask

  // One AW (and optionally AR) handshake plus the matching W last beat, all in RUN.
  task automatic one_write(input logic with_read);
    us_awvalid = 1; ds_awready = 1;
    us_arvalid = with_read; ds_arready = with_read;
    tick();
    us_awvalid = 0; ds_awready = 0; us_arvalid = 0; ds_arready = 0;
    us_wvalid = 1; us_wlast = 1; ds_wready = 1;
    tick();
    us_wvalid = 0; us_wlast = 0; ds_wready = 0;
  endtask

  logic [9:0] got;

  initial begin
    rst_n = 0; sel_req = 0; err_clr = 0;
    us_awid = 9'h1A5; us_awaddr = 64'h0123_4567_89AB_CDEF; us_awlen = 8'd15; us_awsize = 3'd6;
    us_awuser = 11'h5A5;
    us_arid = 9'h0C3; us_araddr = 64'hFEDC_BA98_7654_3210; us_arlen = 8'd3; us_arsize = 3'd6;
    us_aruser = 11'h2AA;
    us_wid = 9'h011; us_wdata = 64'hDEAD_BEEF_CAFE_F00D; us_wstrb = 8'hF0;
    ds_bid = 9'h122; ds_bresp = 2'b10; ds_rid = 9'h033; ds_rdata = 64'h1111_2222_3333_4444;
    ds_rresp = 2'b01;
    all_idle();

    vecs[0] = '{10'b00_00_00_00_00, 10'b00_00_00_00_00};
    vecs[1] = '{10'b11_11_11_11_11, 10'b11_11_11_11_11};
    vecs[2] = '{10'b10_10_10_10_10, 10'b10_10_10_10_10};
    vecs[3] = '{10'b01_01_01_01_01, 10'b01_01_01_01_01};
    vecs[4] = '{10'b11_00_11_00_11, 10'b11_00_11_00_11};
    vecs[5] = '{10'b00_11_00_11_00, 10'b00_11_00_11_00};

    // Gating table under reset: state is RUN and counters are held at zero.
    #2;
    for (int i = 0; i < 6; i++) begin
      {us_awvalid, ds_awready, us_arvalid, ds_arready, us_wvalid, ds_wready,
       ds_bvalid, us_bready, ds_rvalid, us_rready} = vecs[i].vin;
      #1;
      got = {ds_awvalid, us_awready, ds_arvalid, us_arready, ds_wvalid, us_wready,
             us_bvalid, ds_bready, us_rvalid, ds_rready};
      chk($sformatf("gate_vec%0d", i), 64'(got), 64'(vecs[i].vexp));
    end
    chk("pass_awaddr", ds_awaddr, 64'h0123_4567_89AB_CDEF);
    chk("pass_awid", 64'(ds_awid), 64'h1A5);
    chk("pass_aruser", 64'(ds_aruser), 64'h2AA);
    chk("pass_wdata", ds_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("pass_wstrb", 64'(ds_wstrb), 64'hF0);
    chk("pass_bresp", 64'(us_bresp), 64'h2);
    chk("pass_rdata", us_rdata, 64'h1111_2222_3333_4444);
    chk("pass_rid", 64'(us_rid), 64'h033);
    all_idle();
    #1;
    chk("rst_idle_awvalid", 64'(ds_awvalid), 64'd0);
    chk("rst_sel_cur", 64'(sel_cur), 64'd0);
    chk("rst_atg", 64'(atg_enable), 64'd0);
    chk("rst_scrb", 64'(scrb_enable), 64'd0);
    chk("rst_busy", 64'(switch_busy), 64'd0);
    chk("rst_err", 64'(drain_err), 64'd0);
    chk("rst_wr", 64'(wr_outstanding), 64'd0);
    chk("rst_rd", 64'(rd_outstanding), 64'd0);

    tick();
    rst_n = 1;
    tick();

    // Idle switch to the scrubber: busy exactly two cycles, enable on the third.
    sel_req = 2;
    tick();
    chk("idle_busy1", 64'(switch_busy), 64'd1);
    chk("idle_sel_hold", 64'(sel_cur), 64'd0);
    tick();
    chk("idle_busy2", 64'(switch_busy), 64'd1);
    chk("idle_scrb_early", 64'(scrb_enable), 64'd0);
    tick();
    chk("idle_busy_done", 64'(switch_busy), 64'd0);
    chk("idle_scrb", 64'(scrb_enable), 64'd1);
    chk("idle_sel", 64'(sel_cur), 64'd2);
    sel_req = 0;
    repeat (3) tick();
    chk("back_to_slave", 64'(sel_cur), 64'd0);

    // Drain with traffic: 3 AW (len 15), 2 AR, all W beats sent before the request.
    us_awvalid = 1; ds_awready = 1; us_arvalid = 1; ds_arready = 1;
    tick(); tick();
    us_arvalid = 0; ds_arready = 0;
    tick();
    us_awvalid = 0; ds_awready = 0;
    chk("trf_wr3", 64'(wr_outstanding), 64'd3);
    chk("trf_rd2", 64'(rd_outstanding), 64'd2);
    us_wvalid = 1; ds_wready = 1;
    for (int i = 0; i < 48; i++) begin
      us_wlast = ((i % 16) == 15);
      tick();
    end
    us_wvalid = 0; us_wlast = 0; ds_wready = 0;
    sel_req = 1;
    tick();
    us_awvalid = 1; ds_awready = 1; us_arvalid = 1; ds_arready = 1;
    #1;
    chk("trf_aw_gated", 64'(ds_awvalid), 64'd0);
    chk("trf_awready_gated", 64'(us_awready), 64'd0);
    chk("trf_ar_gated", 64'(ds_arvalid), 64'd0);
    chk("trf_arready_gated", 64'(us_arready), 64'd0);
    ds_rvalid = 1; ds_rlast = 1; us_rready = 1;
    tick(); tick();
    ds_rvalid = 0; ds_rlast = 0; us_rready = 0;
    chk("trf_rd0", 64'(rd_outstanding), 64'd0);
    chk("trf_busy", 64'(switch_busy), 64'd1);
    ds_bvalid = 1; us_bready = 1;
    tick(); tick(); tick();
    ds_bvalid = 0; us_bready = 0;
    chk("trf_wr0", 64'(wr_outstanding), 64'd0);
    chk("trf_atg_0", 64'(atg_enable), 64'd0);
    chk("trf_aw_still_gated", 64'(ds_awvalid), 64'd0);
    tick();
    chk("trf_atg_1", 64'(atg_enable), 64'd0);
    us_awvalid = 0; ds_awready = 0; us_arvalid = 0; ds_arready = 0;
    tick();
    chk("trf_atg_2", 64'(atg_enable), 64'd1);
    chk("trf_no_extra_aw", 64'(wr_outstanding), 64'd0);
    chk("trf_err", 64'(drain_err), 64'd0);

    // Stuck AW: valid already presented when the request arrives must stay up.
    us_awvalid = 1; ds_awready = 0; sel_req = 0;
    tick();
    chk("stk_valid_held", 64'(ds_awvalid), 64'd1);
    chk("stk_busy", 64'(switch_busy), 64'd1);
    tick(); tick();
    chk("stk_valid_held2", 64'(ds_awvalid), 64'd1);
    ds_awready = 1;
    #1;
    chk("stk_ready", 64'(us_awready), 64'd1);
    tick();
    us_awvalid = 0; ds_awready = 0;
    chk("stk_wr1", 64'(wr_outstanding), 64'd1);
    tick();
    chk("stk_wait_w", 64'(switch_busy), 64'd1);
    us_wvalid = 1; us_wlast = 1; ds_wready = 1;
    tick();
    us_wvalid = 0; us_wlast = 0; ds_wready = 0;
    tick();
    chk("stk_wait_b", 64'(switch_busy), 64'd1);
    ds_bvalid = 1; us_bready = 1;
    tick();
    ds_bvalid = 0; us_bready = 0;
    tick(); tick();
    chk("stk_sel", 64'(sel_cur), 64'd0);
    chk("stk_busy_done", 64'(switch_busy), 64'd0);

    // Backpressure at MAX_OUTSTANDING.
    us_awvalid = 1; ds_awready = 1;
    repeat (64) tick();
    chk("bp_wr64", 64'(wr_outstanding), 64'd64);
    chk("bp_ready0", 64'(us_awready), 64'd0);
    chk("bp_valid0", 64'(ds_awvalid), 64'd0);
    tick();
    chk("bp_wr64_hold", 64'(wr_outstanding), 64'd64);
    ds_bvalid = 1; us_bready = 1;
    tick();
    ds_bvalid = 0; us_bready = 0;
    chk("bp_wr63", 64'(wr_outstanding), 64'd63);
    chk("bp_ready1", 64'(us_awready), 64'd1);
    tick();
    us_awvalid = 0; ds_awready = 0;
    chk("bp_65th", 64'(wr_outstanding), 64'd64);
    us_wvalid = 1; us_wlast = 1; ds_wready = 1; ds_bvalid = 1; us_bready = 1;
    repeat (64) tick();
    ds_bvalid = 0; us_bready = 0;
    tick();
    us_wvalid = 0; us_wlast = 0; ds_wready = 0;
    chk("bp_drained", 64'(wr_outstanding), 64'd0);

    // Drain timeout with B withheld.
    one_write(1'b0);
    sel_req = 2;
    tick();
    repeat (11) tick();
    chk("to_err_early", 64'(drain_err), 64'd0);
    repeat (9) tick();
    chk("to_err", 64'(drain_err), 64'd1);
    chk("to_sel_hold", 64'(sel_cur), 64'd0);
    chk("to_busy", 64'(switch_busy), 64'd1);
    ds_bvalid = 1; us_bready = 1;
    tick();
    ds_bvalid = 0; us_bready = 0;
    tick(); tick();
    chk("to_sel", 64'(sel_cur), 64'd2);
    chk("to_err_sticky", 64'(drain_err), 64'd1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("to_err_clr", 64'(drain_err), 64'd0);

    // Re-request during drain: first lands on the captured target, then re-drains.
    one_write(1'b0);
    sel_req = 1;
    tick();
    sel_req = 2;
    tick();
    sel_req = 0;
    tick();
    ds_bvalid = 1; us_bready = 1;
    tick();
    ds_bvalid = 0; us_bready = 0;
    tick(); tick();
    chk("rr_first", 64'(sel_cur), 64'd1);
    chk("rr_atg", 64'(atg_enable), 64'd1);
    tick();
    chk("rr_second_busy", 64'(switch_busy), 64'd1);
    tick(); tick();
    chk("rr_second", 64'(sel_cur), 64'd0);
    chk("rr_done", 64'(switch_busy), 64'd0);

    // sel_req 3 is the slave port: no switch from 0.
    sel_req = 3;
    tick(); tick();
    chk("sel3_busy", 64'(switch_busy), 64'd0);
    chk("sel3_sel", 64'(sel_cur), 64'd0);
    sel_req = 0;

    // Reset mid-drain.
    one_write(1'b1);
    chk("rs_rd1", 64'(rd_outstanding), 64'd1);
    sel_req = 1;
    tick();
    chk("rs_busy", 64'(switch_busy), 64'd1);
    rst_n = 0;
    #1;
    chk("rs_sel", 64'(sel_cur), 64'd0);
    chk("rs_busy0", 64'(switch_busy), 64'd0);
    chk("rs_wr0", 64'(wr_outstanding), 64'd0);
    chk("rs_rd0", 64'(rd_outstanding), 64'd0);
    sel_req = 0;
    tick();
    rst_n = 1;
    tick(); tick();
    chk("rs_after_busy", 64'(switch_busy), 64'd0);
    chk("rs_after_sel", 64'(sel_cur), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
